mips_multicycle_ctrl: RTL and testbench

- Parametrised multicycle control unit. It replaces the single-cycle combinational decoder.
- Moore FSM sequencing fetch/decode/execute/memory/writeback over a shared instruction/data memory with a ready handshake.
- Supported instructions: lw, sw, beq, bne, addiu, j, lui, ori, R-type addu/subu/and/or/sltu.
- Sits between the instruction register/zero flag and the multicycle datapath muxes and enables.

---
 rtl/mips_multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback
// over a shared memory, with registered datapath controls.
module mips_multicycle_ctrl #(
   parameter logic MEMREADY_EN = 1'b1,
   parameter logic EXT_EN      = 1'b1,
   parameter int   STATE_W     = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        instr,
   input  logic               zero,
   input  logic               memready,
   output logic               pcen,
   output logic               iord,
   output logic               memread,
   output logic               memwrite,
   output logic               irwrite,
   output logic               regwrite,
   output logic               memtoreg,
   output logic [4:0]         destreg,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [2:0]         alucontrol,
   output logic [1:0]         pcsrc,
   output logic               lui,
   output logic               ori,
   output logic               illegal,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
      S_EXEC, S_ALUWB, S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

   typedef struct packed {
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       memtoreg;
      logic [4:0] destreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucontrol;
      logic [1:0] pcsrc;
      logic       lui;
      logic       ori;
      logic       illegal;
      logic       fetch;
      logic       jump;
      logic       branch;
      logic       isbne;
   } ctrl_t;

   state_t state_q;
   ctrl_t  ctl_q;
   logic   mready;
   logic   unused_bits;

   assign mready      = MEMREADY_EN ? memready : 1'b1;
   assign unused_bits = ^{instr[25:21], instr[10:6]};

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100011: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101011: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic state_t decode_next(input logic [31:0] ir);
      case (ir[31:26])
         6'b100011, 6'b101011: return S_MEMADR;
         6'b000000: begin
            case (ir[5:0])
               6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101011: return S_EXEC;
               default: return S_TRAP;
            endcase
         end
         6'b001001:            return S_IMMEX;
         6'b001111, 6'b001101: return EXT_EN ? S_IMMEX : S_TRAP;
         6'b000100:            return S_BRANCH;
         6'b000101:            return EXT_EN ? S_BRANCH : S_TRAP;
         6'b000010:            return S_JUMP;
         default:              return S_TRAP;
      endcase
   endfunction

   function automatic state_t next_state(input state_t s, input logic [31:0] ir, input logic rdy);
      case (s)
         S_IDLE:   return S_FETCH;
         S_FETCH:  return rdy ? S_DECODE : S_FETCH;
         S_DECODE: return decode_next(ir);
         S_MEMADR: return (ir[31:26] == 6'b101011) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  return rdy ? S_MEMWB : S_MEMRD;
         S_MEMWR:  return rdy ? S_FETCH : S_MEMWR;
         S_EXEC:   return S_ALUWB;
         S_IMMEX:  return S_IMMWB;
         default:  return S_FETCH;
      endcase
   endfunction

   // Control word presented while sitting in state s; IMMEX/IMMWB and EXEC/ALUWB share ALU setup.
   function automatic ctrl_t ctrl_for(input state_t s, input logic [31:0] ir);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH:  begin c.memread = 1'b1; c.alusrcb = 2'b01; c.alucontrol = 3'b010; c.fetch = 1'b1; end
         S_DECODE: begin c.alusrcb = 2'b11; c.alucontrol = 3'b010; end
         S_MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; end
         S_MEMRD:  begin c.iord = 1'b1; c.memread = 1'b1; end
         S_MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.destreg = ir[20:16]; end
         S_MEMWR:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
         S_EXEC:   begin c.alusrca = 1'b1; c.alucontrol = funct_alu(ir[5:0]); end
         S_ALUWB:  begin c.regwrite = 1'b1; c.destreg = ir[15:11]; c.alucontrol = funct_alu(ir[5:0]); end
         S_IMMEX, S_IMMWB: begin
            if (ir[31:26] == 6'b001101) begin
               c.ori = 1'b1; c.alucontrol = 3'b001;
            end else if (ir[31:26] == 6'b001111) begin
               c.lui = 1'b1;
            end else begin
               c.alucontrol = 3'b010;
            end
            if (s == S_IMMEX) begin
               c.alusrca = 1'b1; c.alusrcb = 2'b10;
            end else begin
               c.regwrite = 1'b1; c.destreg = ir[20:16];
            end
         end
         S_BRANCH: begin
            c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01;
            c.branch = 1'b1; c.isbne = ir[26];
         end
         S_JUMP:   begin c.pcsrc = 2'b10; c.jump = 1'b1; end
         S_TRAP:   c.illegal = 1'b1;
         default:  c = '0;
      endcase
      return c;
   endfunction

   // NOTE: the control word is computed for the state being entered, so it registers
   // together with the state and every output is a flop except the memready/zero gating.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ctl_q   <= '0;
      end else begin
         state_q <= next_state(state_q, instr, mready);
         ctl_q   <= ctrl_for(next_state(state_q, instr, mready), instr);
      end
   end

   assign iord       = ctl_q.iord;
   assign memread    = ctl_q.memread;
   assign memwrite   = ctl_q.memwrite;
   assign regwrite   = ctl_q.regwrite;
   assign memtoreg   = ctl_q.memtoreg;
   assign destreg    = ctl_q.destreg;
   assign alusrca    = ctl_q.alusrca;
   assign alusrcb    = ctl_q.alusrcb;
   assign alucontrol = ctl_q.alucontrol;
   assign pcsrc      = ctl_q.pcsrc;
   assign lui        = ctl_q.lui;
   assign ori        = ctl_q.ori;
   assign illegal    = ctl_q.illegal;
   assign irwrite    = ctl_q.fetch & mready;
   assign pcen       = (ctl_q.fetch & mready) | ctl_q.jump | (ctl_q.branch & (zero ^ ctl_q.isbne));
   assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: a phase-level instruction model pushes
// per-cycle expected controls; a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

   typedef struct packed {
      logic       pcen;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic       memtoreg;
      logic [4:0] destreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] alucontrol;
      logic [1:0] pcsrc;
      logic       lui;
      logic       ori;
      logic       illegal;
   } vec_t;

   localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                  P_MEMWB = 5, P_MEMWR = 6, P_EXEC = 7, P_ALUWB = 8, P_IMMEX = 9,
                  P_IMMWB = 10, P_BRANCH = 11, P_JUMP = 12, P_TRAP = 13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b, zero, memready;
   logic [31:0] instr;

   logic pcen_a, iord_a, memread_a, memwrite_a, irwrite_a, regwrite_a, memtoreg_a;
   logic alusrca_a, lui_a, ori_a, illegal_a;
   logic [4:0] destreg_a;
   logic [1:0] alusrcb_a, pcsrc_a;
   logic [2:0] alucontrol_a;
   logic [3:0] state_a;
   logic pcen_b, iord_b, memread_b, memwrite_b, irwrite_b, regwrite_b, memtoreg_b;
   logic alusrca_b, lui_b, ori_b, illegal_b;
   logic [4:0] destreg_b;
   logic [1:0] alusrcb_b, pcsrc_b;
   logic [2:0] alucontrol_b;
   logic [3:0] state_b;

   mips_multicycle_ctrl #(.MEMREADY_EN(1'b1), .EXT_EN(1'b1), .STATE_W(4)) dut_a (
      .clk(clk), .reset(rst_a), .instr(instr), .zero(zero), .memready(memready),
      .pcen(pcen_a), .iord(iord_a), .memread(memread_a), .memwrite(memwrite_a),
      .irwrite(irwrite_a), .regwrite(regwrite_a), .memtoreg(memtoreg_a),
      .destreg(destreg_a), .alusrca(alusrca_a), .alusrcb(alusrcb_a),
      .alucontrol(alucontrol_a), .pcsrc(pcsrc_a), .lui(lui_a), .ori(ori_a),
      .illegal(illegal_a), .state(state_a));

   mips_multicycle_ctrl #(.MEMREADY_EN(1'b0), .EXT_EN(1'b0), .STATE_W(4)) dut_b (
      .clk(clk), .reset(rst_b), .instr(instr), .zero(zero), .memready(memready),
      .pcen(pcen_b), .iord(iord_b), .memread(memread_b), .memwrite(memwrite_b),
      .irwrite(irwrite_b), .regwrite(regwrite_b), .memtoreg(memtoreg_b),
      .destreg(destreg_b), .alusrca(alusrca_b), .alusrcb(alusrcb_b),
      .alucontrol(alucontrol_b), .pcsrc(pcsrc_b), .lui(lui_b), .ori(ori_b),
      .illegal(illegal_b), .state(state_b));

   vec_t obs_a, obs_b;
   assign obs_a = {pcen_a, iord_a, memread_a, memwrite_a, irwrite_a, regwrite_a, memtoreg_a,
                   destreg_a, alusrca_a, alusrcb_a, alucontrol_a, pcsrc_a, lui_a, ori_a, illegal_a};
   assign obs_b = {pcen_b, iord_b, memread_b, memwrite_b, irwrite_b, regwrite_b, memtoreg_b,
                   destreg_b, alusrca_b, alusrcb_b, alucontrol_b, pcsrc_b, lui_b, ori_b, illegal_b};

   vec_t  exp_q[$];
   string tag_q[$];
   int    vectors = 0;
   int    miscompares = 0;
   logic  sel = 1'b0;   // 0: dut_a (full features), 1: dut_b (no memready, no extensions)

   task automatic check(input string name, input vec_t got, input vec_t exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         vec_t  e;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check($sformatf("%s st=%0d", t, sel ? state_b : state_a), sel ? obs_b : obs_a, e);
      end
   end

   function automatic logic [2:0] alu_of(input logic [5:0] f);
      case (f)
         6'h21:   return 3'b010;
         6'h23:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         default: return 3'b111;
      endcase
   endfunction

   // Expected controls for one cycle spent in phase ph.
   function automatic vec_t expect_for(input int ph, input logic [31:0] ir, input logic z, input logic mr);
      vec_t v;
      logic [5:0] op;
      v  = '0;
      op = ir[31:26];
      case (ph)
         P_FETCH:  begin v.memread = 1; v.alusrcb = 2'b01; v.alucontrol = 3'b010; v.irwrite = mr; v.pcen = mr; end
         P_DECODE: begin v.alusrcb = 2'b11; v.alucontrol = 3'b010; end
         P_MEMADR: begin v.alusrca = 1; v.alusrcb = 2'b10; v.alucontrol = 3'b010; end
         P_MEMRD:  begin v.iord = 1; v.memread = 1; end
         P_MEMWB:  begin v.regwrite = 1; v.memtoreg = 1; v.destreg = ir[20:16]; end
         P_MEMWR:  begin v.iord = 1; v.memwrite = 1; end
         P_EXEC:   begin v.alusrca = 1; v.alucontrol = alu_of(ir[5:0]); end
         P_ALUWB:  begin v.regwrite = 1; v.destreg = ir[15:11]; v.alucontrol = alu_of(ir[5:0]); end
         P_IMMEX, P_IMMWB: begin
            if (op == 6'h0D) begin v.ori = 1; v.alucontrol = 3'b001; end
            else if (op == 6'h0F) v.lui = 1;
            else v.alucontrol = 3'b010;
            if (ph == P_IMMEX) begin v.alusrca = 1; v.alusrcb = 2'b10; end
            else begin v.regwrite = 1; v.destreg = ir[20:16]; end
         end
         P_BRANCH: begin v.alusrca = 1; v.alucontrol = 3'b110; v.pcsrc = 2'b01; v.pcen = z ^ op[0]; end
         P_JUMP:   begin v.pcsrc = 2'b10; v.pcen = 1; end
         P_TRAP:   v.illegal = 1;
         default:  v = '0;
      endcase
      return v;
   endfunction

   task automatic step(input int ph, input string tag, input logic z, input logic mr, input logic rst);
      zero     = z;
      memready = mr;
      if (sel) rst_b = rst; else rst_a = rst;
      exp_q.push_back(expect_for(ph, instr, z, sel ? 1'b1 : mr));
      tag_q.push_back($sformatf("%s ph=%0d ir=%h", tag, ph, instr));
      @(posedge clk);
      #1;
   endtask

   // A memory-waiting phase: waits cycles with memready low, then one ready cycle.
   task automatic wait_phase(input int ph, input string tag, input logic z, input int waits);
      if (!sel)
         for (int i = 0; i < waits; i++) step(ph, tag, z, 1'b0, 1'b1);
      step(ph, tag, z, sel ? 1'($urandom) : 1'b1, 1'b1);
   endtask

   task automatic do_instr(input logic [31:0] ir, input logic z, input int wf, input int wm, input string tag);
      int plan[$];
      logic [5:0] op;
      logic [5:0] f;
      logic ext;
      op  = ir[31:26];
      f   = ir[5:0];
      ext = !sel;
      instr = ir;
      if (op == 6'h23) plan = '{P_MEMADR, P_MEMRD, P_MEMWB};
      else if (op == 6'h2B) plan = '{P_MEMADR, P_MEMWR};
      else if (op == 6'h00 && (f == 6'h21 || f == 6'h23 || f == 6'h24 || f == 6'h25 || f == 6'h2B))
         plan = '{P_EXEC, P_ALUWB};
      else if (op == 6'h09 || (ext && (op == 6'h0F || op == 6'h0D))) plan = '{P_IMMEX, P_IMMWB};
      else if (op == 6'h04 || (ext && op == 6'h05)) plan = '{P_BRANCH};
      else if (op == 6'h02) plan = '{P_JUMP};
      else plan = '{P_TRAP};
      wait_phase(P_FETCH, tag, z, wf);
      step(P_DECODE, tag, z, 1'($urandom), 1'b1);
      foreach (plan[i]) begin
         if (plan[i] == P_MEMRD || plan[i] == P_MEMWR) wait_phase(plan[i], tag, z, wm);
         else step(plan[i], tag, z, 1'($urandom), 1'b1);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [5:0]  fn;
      r = $urandom;
      case ($urandom_range(0, 4))
         0: fn = 6'h21;
         1: fn = 6'h23;
         2: fn = 6'h24;
         3: fn = 6'h25;
         default: fn = 6'h2B;
      endcase
      case ($urandom_range(0, 12))
         0: return {6'h23, r[25:0]};
         1: return {6'h2B, r[25:0]};
         2: return {6'h04, r[25:0]};
         3: return {6'h05, r[25:0]};
         4: return {6'h09, r[25:0]};
         5: return {6'h02, r[25:0]};
         6: return {6'h0F, r[25:0]};
         7: return {6'h0D, r[25:0]};
         8, 9, 10: return {6'h00, r[25:6], fn};
         11: return {6'h00, r[25:0]};
         default: return r;
      endcase
   endfunction

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; zero = 1'b0; memready = 1'b0; instr = '0;
      @(posedge clk);
      #1;
      // dut_a: reset state, then directed cases
      step(P_IDLE, "reset", 1'b1, 1'b1, 1'b0);
      step(P_IDLE, "release", 1'b1, 1'b1, 1'b1);
      do_instr(32'h8C080004, 1'b0, 0, 0, "lw");
      do_instr(32'h01095021, 1'b0, 0, 0, "addu");
      do_instr(32'h1109FFFE, 1'b1, 0, 0, "beq");
      do_instr(32'h1509FFFE, 1'b1, 0, 0, "bne");
      do_instr(32'hAC080008, 1'b0, 0, 3, "sw_wait");
      do_instr(32'hFC000000, 1'b0, 0, 0, "illegal");
      do_instr(32'h3C011234, 1'b0, 0, 0, "lui");
      do_instr(32'h3508ABCD, 1'b0, 1, 0, "ori");
      do_instr(32'h08000010, 1'b0, 0, 0, "j");
      // reset held two cycles while lw waits in MEMRD
      instr = 32'h8C080004;
      step(P_FETCH, "rst_mid", 1'b0, 1'b1, 1'b1);
      step(P_DECODE, "rst_mid", 1'b0, 1'b1, 1'b1);
      step(P_MEMADR, "rst_mid", 1'b0, 1'b1, 1'b1);
      step(P_MEMRD, "rst_mid", 1'b0, 1'b0, 1'b0);
      step(P_IDLE, "rst_mid", 1'b1, 1'b1, 1'b0);
      step(P_IDLE, "rst_mid", 1'b1, 1'b1, 1'b1);
      do_instr(32'h8C080004, 1'b1, 2, 1, "lw_after_rst");
      for (int n = 0; n < 200; n++)
         do_instr(rand_instr(), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), "rand_a");
      @(negedge clk);
      #1;
      rst_a = 1'b0;
      sel   = 1'b1;
      @(posedge clk);
      #1;
      // dut_b: no extensions, memready ignored
      step(P_IDLE, "reset_b", 1'b0, 1'b0, 1'b0);
      step(P_IDLE, "release_b", 1'b0, 1'b0, 1'b1);
      do_instr(32'h3C011234, 1'b0, 2, 0, "lui_noext");
      do_instr(32'h1509FFFE, 1'b1, 0, 0, "bne_noext");
      do_instr(32'h3508ABCD, 1'b0, 0, 0, "ori_noext");
      do_instr(32'h8C080004, 1'b0, 3, 3, "lw_nomr");
      do_instr(32'hAC080008, 1'b0, 2, 2, "sw_nomr");
      for (int n = 0; n < 60; n++)
         do_instr(rand_instr(), 1'($urandom), 1, 1, "rand_b");
      for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
